// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the MIPS control unit: opcode and
//                funct values, ALUControl codes, FSM state encoding and the
//                raw decode bundle produced by mips_main_dec.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALUControl encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    // Control FSM states
    typedef enum logic [1:0] {
        S_RUN = 2'b00,
        S_MEM = 2'b01,
        S_ERR = 2'b10
    } state_e;

    // Raw (ungated) decode of one instruction word
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       mem_to_reg;
        logic       branch_eq;
        logic       branch_ne;
        logic       mem_write;
        logic       is_mem;
        logic       illegal;
        logic [3:0] alu_ctl;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/mips_main_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mips_main_dec
//  Description : Purely combinational instruction decoder. Produces the raw
//                datapath strobes for Instr; sequencing and gating are done
//                by the caller.
//  Ports       : instr_i  32-bit instruction word
//                dec_o    decoded strobe bundle (dec_t)
//  Revision    : 1.0  initial release
// ============================================================================
module mips_main_dec
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_op    = instr_i[31:26];
    assign w_funct = instr_i[5:0];
    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused_fields = ^instr_i[25:6];

    always_comb begin
        dec_o = '0;
        case (w_op)
            OP_RTYPE: begin
                dec_o.reg_dst   = 1'b1;
                dec_o.reg_write = 1'b1;
                case (w_funct)
                    F_ADD: dec_o.alu_ctl = ALU_ADD;
                    F_SUB: dec_o.alu_ctl = ALU_SUB;
                    F_AND: dec_o.alu_ctl = ALU_AND;
                    F_OR:  dec_o.alu_ctl = ALU_OR;
                    F_SLT: dec_o.alu_ctl = ALU_SLT;
                    F_NOR: dec_o.alu_ctl = ALU_NOR;
                    F_SLL: dec_o.alu_ctl = ALU_SLL;
                    F_SRL: dec_o.alu_ctl = ALU_SRL;
                    F_JR: begin
                        dec_o.reg_dst   = 1'b0;
                        dec_o.reg_write = 1'b0;
                        dec_o.jr        = 1'b1;
                    end
                    default: begin
                        dec_o.reg_dst   = 1'b0;
                        dec_o.reg_write = 1'b0;
                        dec_o.illegal   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_o.alu_src    = 1'b1;
                dec_o.reg_write  = 1'b1;   // only honoured on the ack cycle
                dec_o.mem_to_reg = 1'b1;
                dec_o.is_mem     = 1'b1;
                dec_o.alu_ctl    = ALU_ADD;
            end
            OP_SW: begin
                dec_o.alu_src   = 1'b1;
                dec_o.mem_write = 1'b1;
                dec_o.is_mem    = 1'b1;
                dec_o.alu_ctl   = ALU_ADD;
            end
            OP_BEQ: begin
                dec_o.branch_eq = 1'b1;
                dec_o.alu_ctl   = ALU_SUB;
            end
            OP_BNE: begin
                dec_o.branch_ne = 1'b1;
                dec_o.alu_ctl   = ALU_SUB;
            end
            OP_ADDI: begin
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.alu_ctl   = ALU_ADD;
            end
            OP_J: begin
                dec_o.jump = 1'b1;
            end
            OP_JAL: begin
                dec_o.jal       = 1'b1;
                dec_o.reg_write = 1'b1;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_ctrl
//  Description : Control unit for the single-cycle MIPS datapath. Decodes
//                Instr into datapath strobes, sequences loads/stores against
//                a req/ack data memory while holding the PC via PCEn, flags
//                memory timeouts (sticky) and counts retired instructions.
//  Ports       : clk, reset (async, active-low), Instr, ZeroFlag, MemAck
//                -> RegDst, RegWrite, ALUSrc, Jump, JAL, JR, MemtoReg,
//                   PCSrc, ALUControl, MemWrite, MemReq, PCEn, Illegal,
//                   MemErr, RetireCnt
//  Revision    : 1.0  initial release
// ============================================================================
module mips_mem_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             ZeroFlag,
    input  logic             MemAck,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             Jump,
    output logic             JAL,
    output logic             JR,
    output logic             MemtoReg,
    output logic             PCSrc,
    output logic [3:0]       ALUControl,
    output logic             MemWrite,
    output logic             MemReq,
    output logic             PCEn,
    output logic             Illegal,
    output logic             MemErr,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Last counter value at which a missing ack still moves to S_ERR on
    // the same edge: the counter would then reach TIMEOUT-1.
    localparam int TO_LAST = (TIMEOUT >= 2) ? (TIMEOUT - 2) : 0;

    dec_t              w_dec;
    state_e            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  retire_q;
    logic              w_timeout;

    mips_main_dec u_dec (
        .instr_i (Instr),
        .dec_o   (w_dec)
    );

    assign w_timeout = (tcnt_q >= TW'(TO_LAST));

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        err_d      = err_q;
        RegDst     = w_dec.reg_dst;
        ALUSrc     = w_dec.alu_src;
        ALUControl = w_dec.alu_ctl;
        MemtoReg   = w_dec.mem_to_reg;
        RegWrite   = 1'b0;
        Jump       = 1'b0;
        JAL        = 1'b0;
        JR         = 1'b0;
        PCSrc      = 1'b0;
        MemWrite   = 1'b0;
        MemReq     = 1'b0;
        PCEn       = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_dec.is_mem) begin
                    // Launch the access; MemAck is not looked at here.
                    MemReq   = 1'b1;
                    MemWrite = w_dec.mem_write;
                    tcnt_d   = '0;
                    state_d  = S_MEM;
                end else begin
                    RegWrite = w_dec.reg_write;
                    Jump     = w_dec.jump;
                    JAL      = w_dec.jal;
                    JR       = w_dec.jr;
                    PCSrc    = (w_dec.branch_eq & ZeroFlag) |
                               (w_dec.branch_ne & ~ZeroFlag);
                    PCEn     = 1'b1;
                end
            end
            S_MEM: begin
                MemReq   = 1'b1;
                MemWrite = w_dec.mem_write;
                if (MemAck) begin
                    RegWrite = w_dec.reg_write;   // set for lw, clear for sw
                    PCEn     = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (w_timeout) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                // Terminal until reset; all enables stay low.
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Reset gates the enables combinationally so MemReq drops at once.
        if (!reset) begin
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemReq   = 1'b0;
            PCEn     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            if (PCEn) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    assign Illegal   = w_dec.illegal;
    assign MemErr    = err_q;
    assign RetireCnt = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_mem_ctrl
//  Description : Scoreboard bench for mips_mem_ctrl. The driver applies one
//                directed vector per cycle and queues its expected strobes;
//                a monitor pops and compares on every falling edge.
//                Strobe patterns read, left to right:
//                  RegDst RegWrite ALUSrc Jump _ JAL JR MemtoReg PCSrc _
//                  ALUControl[3:0] _ MemWrite MemReq PCEn Illegal MemErr
//                with '-' marking a don't-care bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_mem_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      Instr = 32'h0;
    logic             ZeroFlag = 1'b0;
    logic             MemAck = 1'b0;
    logic             RegDst, RegWrite, ALUSrc, Jump, JAL, JR, MemtoReg, PCSrc;
    logic [3:0]       ALUControl;
    logic             MemWrite, MemReq, PCEn, Illegal, MemErr;
    logic [CNT_W-1:0] RetireCnt;

    always #5 clk = ~clk;

    mips_mem_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ZeroFlag   (ZeroFlag),
        .MemAck     (MemAck),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .Jump       (Jump),
        .JAL        (JAL),
        .JR         (JR),
        .MemtoReg   (MemtoReg),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .MemWrite   (MemWrite),
        .MemReq     (MemReq),
        .PCEn       (PCEn),
        .Illegal    (Illegal),
        .MemErr     (MemErr),
        .RetireCnt  (RetireCnt)
    );

    typedef struct {
        string            name;
        logic [16:0]      val;
        logic [16:0]      msk;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [16:0]      w_act;

    assign w_act = {RegDst, RegWrite, ALUSrc, Jump, JAL, JR, MemtoReg, PCSrc,
                    ALUControl, MemWrite, MemReq, PCEn, Illegal, MemErr};

    // Patterns
    localparam string P_RST  = "-0--_----_----_00000";
    localparam string P_ERR  = "-0--_----_----_00001";
    localparam string P_LWR  = "0010_00-0_0010_01000";
    localparam string P_LWA  = "0110_0010_0010_01100";
    localparam string P_SW   = "-010_00-0_0010_11000";
    localparam string P_ADD  = "1100_0000_0010_00100";

    function automatic void parse(input string s, output logic [16:0] v,
                                  output logic [16:0] m);
        v = '0;
        m = '0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "_") continue;
            v = {v[15:0], s[i] == "1"};
            m = {m[15:0], s[i] != "-"};
        end
    endfunction

    task automatic step(input string name, input logic [31:0] ins,
                        input bit z, input bit ack, input bit rstn,
                        input string pat, input bit ret);
        exp_t e;
        @(posedge clk);
        #1;
        Instr    = ins;
        ZeroFlag = z;
        MemAck   = ack;
        reset    = rstn;
        if (!rstn) exp_cnt = '0;
        parse(pat, e.val, e.msk);
        e.name = name;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (ret) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Monitor: compares every queued expectation half a cycle after it is set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if ((w_act & e.msk) !== (e.val & e.msk)) begin
                    n_fail++;
                    $display("FAIL %s strobes: got %b expected %b (mask %b)",
                             e.name, w_act, e.val, e.msk);
                end
                n_tests++;
                if (RetireCnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s RetireCnt: got %0d expected %0d",
                             e.name, RetireCnt, e.cnt);
                end
            end
        end
    end

    initial begin
        // Reset held with an add on the bus
        for (int i = 0; i < 3; i++) step("reset_add", 32'h00221820, 0, 0, 0, P_RST, 0);
        step("add_release", 32'h00221820, 0, 0, 1, P_ADD, 1);
        step("add_again",   32'h00221820, 0, 0, 1, P_ADD, 1);

        // lw, ack on the third S_MEM cycle
        step("lw_run",  32'h8E080004, 0, 0, 1, P_LWR, 0);
        step("lw_mem1", 32'h8E080004, 0, 0, 1, P_LWR, 0);
        step("lw_mem2", 32'h8E080004, 0, 0, 1, P_LWR, 0);
        step("lw_ack3", 32'h8E080004, 0, 1, 1, P_LWA, 1);
        // lw, ack present already in S_RUN (ignored) -> minimum latency 2
        step("lw2_run", 32'h8E080004, 0, 1, 1, P_LWR, 0);
        step("lw2_ack", 32'h8E080004, 0, 1, 1, P_LWA, 1);

        // Branches
        step("beq_z1", 32'h10220003, 1, 0, 1, "0000_0001_0110_00100", 1);
        step("beq_z0", 32'h10220003, 0, 0, 1, "0000_0000_0110_00100", 1);
        step("bne_z1", 32'h14220003, 1, 0, 1, "0000_0000_0110_00100", 1);
        step("bne_z0", 32'h14220003, 0, 0, 1, "0000_0001_0110_00100", 1);

        // Jumps
        step("jal", 32'h0C000010, 0, 0, 1, "-100_10-0_----_00100", 1);
        step("jr",  32'h03E00008, 0, 0, 1, "--00_01-0_----_00100", 1);
        step("j",   32'h08000010, 0, 0, 1, "-0-1_00-0_----_00100", 1);

        // Remaining ALU ops
        step("sub",  32'h00221822, 0, 0, 1, "1100_0000_0110_00100", 1);
        step("and",  32'h00221824, 0, 0, 1, "1100_0000_0000_00100", 1);
        step("or",   32'h00221825, 0, 0, 1, "1100_0000_0001_00100", 1);
        step("slt",  32'h0022182A, 0, 0, 1, "1100_0000_0111_00100", 1);
        step("nor",  32'h00221827, 0, 0, 1, "1100_0000_1100_00100", 1);
        step("sll0", 32'h00000000, 0, 0, 1, "1100_0000_1000_00100", 1);
        step("srl",  32'h00221802, 0, 0, 1, "1100_0000_1001_00100", 1);
        step("addi", 32'h20220005, 0, 0, 1, "0110_0000_0010_00100", 1);

        // Illegal opcode and illegal funct execute as NOP and retire
        step("ill_op",    32'hFC000000, 0, 0, 1, "-0-0_00-0_----_00110", 1);
        step("ill_funct", 32'h0000003F, 0, 0, 1, "-0-0_00-0_----_00110", 1);

        // Reset in the middle of a load
        step("lwr_run",   32'h8E080004, 0, 0, 1, P_LWR, 0);
        step("lwr_mem",   32'h8E080004, 0, 0, 1, P_LWR, 0);
        step("lwr_reset", 32'h8E080004, 0, 1, 0, P_RST, 0);
        step("lwr_after", 32'h00221820, 0, 0, 1, P_ADD, 1);

        // Store timing out (TIMEOUT=4): four request cycles then S_ERR
        step("sw_run",  32'hAE080008, 0, 0, 1, P_SW, 0);
        for (int i = 0; i < 3; i++) step("sw_mem", 32'hAE080008, 0, 0, 1, P_SW, 0);
        step("err_hold",  32'hAE080008, 0, 0, 1, P_ERR, 0);
        step("err_ack",   32'hAE080008, 0, 1, 1, P_ERR, 0);
        step("err_add",   32'h00221820, 0, 0, 1, P_ERR, 0);
        step("err_add2",  32'h00221820, 0, 1, 1, P_ERR, 0);
        step("err_reset", 32'h00221820, 0, 0, 0, P_RST, 0);
        step("err_clear", 32'h00221820, 0, 0, 1, P_ADD, 1);

        // Retire counter wraps through all-ones back to 0
        for (int i = 0; i < 260; i++) step("wrap_add", 32'h00221820, 0, 0, 1, P_ADD, 1);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mem_ctrl.md
Name: mips_mem_ctrl

Overview:
- Control unit for the single-cycle MIPS datapath.
- Decodes Instr into every datapath control strobe (RegDst, RegWrite, ALUSrc, Jump, JAL, JR, MemtoReg, PCSrc, ALUControl).
- Sequences loads and stores against a data memory with a req/ack handshake, stalling the PC via PCEn until the access completes.
- Provides timeout detection, illegal-opcode flagging and a retired-instruction counter.

Parameters:
TIMEOUT, 16, max cycles in S_MEM waiting for MemAck before error (≥1)
CNT_W, 32, width of RetireCnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
Instr  in  32  current instruction word
ZeroFlag  in  1  ALU zero from datapath
MemAck  in  1  data memory completion, valid only in S_MEM
RegDst  out  1  write reg = rd (1) / rt (0)
RegWrite  out  1  register-file write enable
ALUSrc  out  1  ALU operand B = sign-extended imm
Jump  out  1  j target select
JAL  out  1  link: write PC+4 to $31
JR  out  1  PC ← rs
MemtoReg  out  1  writeback = ReadData
PCSrc  out  1  take branch
ALUControl  out  4  ALU function
MemWrite  out  1  store strobe
MemReq  out  1  data memory request
PCEn  out  1  PC register update enable (datapath PC flop gated by this)
Illegal  out  1  current Instr undecodable (combinational)
MemErr  out  1  sticky timeout error
RetireCnt  out  CNT_W  instructions retired

Behaviour:
- Decode (combinational). Opcode 000000 is R-type; funct values:
  - add 100000 → ALU 0010
  - sub 100010 → 0110
  - and 100100 → 0000
  - or 100101 → 0001
  - slt 101010 → 0111
  - nor 100111 → 1100
  - sll 000000 → 1000
  - srl 000010 → 1001
  - jr 001000 → JR=1, RegWrite=0
- Other opcodes:
  - lw 100011, sw 101011: ALUSrc=1, ALU 0010
  - beq 000100 / bne 000101: ALU 0110; PCSrc = ZeroFlag / ~ZeroFlag
  - addi 001000: ALUSrc=1, RegWrite, ALU 0010
  - j 000010: Jump=1
  - jal 000011: JAL=1, RegWrite=1
- Any unlisted opcode/funct: Illegal=1, all write/branch/jump strobes 0, PCEn=1 (executes as NOP and retires).
- sll $0,$0,0 (0x00000000) is legal; it writes $0, which the regfile ignores.
- FSM states: S_RUN, S_MEM, S_ERR. Reset (reset=0) forces S_RUN, RetireCnt=0, MemErr=0, timeout counter=0.
  - While reset is low: PCEn=0, RegWrite=0, MemWrite=0, MemReq=0.
- S_RUN, non-memory instruction:
  - Strobes as decoded, PCEn=1, RetireCnt+1, stay. Latency 1 cycle.
- S_RUN, lw/sw:
  - MemReq=1, MemWrite=(sw), RegWrite=0, PCEn=0, counter cleared, → S_MEM.
  - MemAck in S_RUN is ignored.
- S_MEM:
  - MemReq=1 held; MemWrite held for sw; Instr assumed stable (PC frozen).
  - MemAck=1: for lw assert RegWrite=1, MemtoReg=1. PCEn=1, RetireCnt+1, → S_RUN.
  - MemAck=0: counter+1; when counter reaches TIMEOUT-1 with no ack → S_ERR, MemErr=1.
  - Minimum memory instruction latency is 2 cycles.
- S_ERR:
  - PCEn, RegWrite, MemWrite, MemReq all 0; MemErr held.
  - Exit only via reset.
- RetireCnt wraps from all-ones to 0.
- Reset asserted mid-S_MEM: immediate return to S_RUN, MemReq drops asynchronously, no register write.

Decomposition:
- Shared package mips_pkg: opcode/funct localparams, ALUControl encodings, FSM state encoding (2 bits).
- Sub-module mips_main_dec: pure combinational decode of Instr → raw strobes + is_mem + Illegal.
- FSM, counters and gating live in mips_mem_ctrl.

Test Plan:
- Reset low 3 cycles with Instr=0x00221820 → all enables 0, RetireCnt=0. Release → same cycle RegDst=1, RegWrite=1, ALUControl=0010, PCEn=1; RetireCnt=1 after edge.
- lw 0x8E080004, MemAck raised on 3rd S_MEM cycle:
  - MemReq=1 for 3 cycles, PCEn=0 until ack cycle.
  - Ack cycle: RegWrite=1, MemtoReg=1, PCEn=1.
  - RetireCnt +1 total.
- sw 0xAE080008 with TIMEOUT=4, MemAck never → MemWrite/MemReq high 4 cycles, then S_ERR, MemErr=1, PCEn=0 indefinitely; reset clears.
- beq 0x10220003 with ZeroFlag=1 → PCSrc=1; ZeroFlag=0 → PCSrc=0. bne 0x14220003 gives inverse.
- jal 0x0C000010 → JAL=1, Jump=0, RegWrite=1. jr $31 0x03E00008 → JR=1, RegWrite=0.
- Illegal 0xFC000000 → Illegal=1, no writes, PCEn=1. Reset asserted during S_MEM of lw → MemReq drops immediately, no RegWrite, RetireCnt=0.
